// File: rtl/modulo_varredura_matriz_pkg.sv
// Shared definitions for 5x7 LED-matrix pattern readers: geometry,
// the "all rows off" drive value, scan states and the bit-mapping helper.
package modulo_varredura_matriz_pkg;

    localparam int NUM_ROWS  = 7;
    localparam int NUM_COLS  = 5;
    localparam int PATTERN_W = 35;

    // Row drive is active-low, so all ones turns every row off.
    localparam logic [NUM_ROWS-1:0] LIN_OFF = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_BLANK = 2'd2,
        ST_SHOW  = 2'd3
    } state_e;

    // Pattern is row-major, 5 bits per row, bit 34 is the top-left LED.
    function automatic int bit_index(input int r, input int c);
        return (PATTERN_W - 1) - (NUM_COLS * r) - c;
    endfunction

endpackage

// File: rtl/modulo_sel_coluna.sv
// Extracts one 7-row column from a 35-bit 5x7 pattern. Pattern bits pass
// straight through (0 = lit), so the result can drive active-low rows.
// An out-of-range column index yields all rows off.
module modulo_sel_coluna
    import modulo_varredura_matriz_pkg::*;
(
    input  logic [34:0] snap_i,
    input  logic [2:0]  idx_i,
    output logic [6:0]  lin_o
);

    // Pick the bit of every row that belongs to the selected column.
    always_comb begin
        lin_o = LIN_OFF;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (idx_i == 3'(c)) begin
                    lin_o[r] = snap_i[6'(bit_index(r, c))];
                end
            end
        end
    end

endmodule

// File: rtl/modulo_varredura_matriz.sv
// Scans a 5x7 LED matrix column by column from a per-frame snapshot of the
// pattern bank. Each frame: one LOAD cycle (snapshot taken at its end), then
// for each of the 5 columns BLANK dark cycles followed by DWELL lit cycles.
// Outputs are registered from the next-state values so they always reflect
// the current state registers exactly.
module modulo_varredura_matriz
    import modulo_varredura_matriz_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    input  logic [34:0] m_in,
    output logic [4:0]  col,
    output logic [6:0]  lin,
    output logic        frame_sync
);

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);
    // With no blanking, a column hands over directly to the next column.
    localparam state_e      COL_ENTRY  = (BLANK == 0) ? ST_SHOW : ST_BLANK;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [34:0] snap_q, snap_d;
    logic [4:0]  col_q, col_d;
    logic [6:0]  lin_q, lin_d;
    logic        fs_q, fs_d;
    logic [6:0]  sel_lin;

    modulo_sel_coluna u_sel (
        .snap_i (snap_d),
        .idx_i  (idx_d),
        .lin_o  (sel_lin)
    );

    // Next-state logic: frame sequencing, dwell/blank timing, snapshot capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        idx_d   = idx_q;
        snap_d  = snap_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                snap_d  = m_in;
                idx_d   = '0;
                state_d = COL_ENTRY;
            end
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 3'(NUM_COLS - 1)) begin
                        // en is only honoured here, so a frame always completes.
                        idx_d   = '0;
                        state_d = en ? ST_LOAD : ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = COL_ENTRY;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so registered outputs track the state.
    always_comb begin
        col_d = '0;
        lin_d = LIN_OFF;
        fs_d  = (state_d == ST_LOAD);
        if (state_d == ST_SHOW) begin
            col_d[idx_d] = 1'b1;
            lin_d        = sel_lin;
        end
    end

    // State, counter, snapshot and output registers; reset blanks the matrix at once.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '1;
            col_q   <= '0;
            lin_q   <= LIN_OFF;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            col_q   <= col_d;
            lin_q   <= lin_d;
            fs_q    <= fs_d;
        end
    end

    assign col        = col_q;
    assign lin        = lin_q;
    assign frame_sync = fs_q;

endmodule

// File: tb/tb_modulo_varredura_matriz.sv
// Bench for the LED-matrix scanner: two instances (DWELL=4/BLANK=1 and
// DWELL=1/BLANK=0) share the stimulus; a frame-position model predicts the
// outputs of both every cycle, and directed checks pin key literal values.
module tb_modulo_varredura_matriz;

    localparam int D1 = 4, B1 = 1, P1 = 1 + 5 * (B1 + D1);
    localparam int D2 = 1, B2 = 0, P2 = 1 + 5 * (B2 + D2);
    localparam logic [34:0] ONES = {35{1'b1}};

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        en = 1'b1;
    logic [34:0] m_in = ONES;
    logic [4:0]  col1, col2;
    logic [6:0]  lin1, lin2;
    logic        fs1, fs2;

    int vectors = 0;
    int miscompares = 0;

    modulo_varredura_matriz #(.DWELL(D1), .BLANK(B1)) u_dut1 (
        .clk(clk), .clr(clr), .en(en), .m_in(m_in),
        .col(col1), .lin(lin1), .frame_sync(fs1)
    );

    modulo_varredura_matriz #(.DWELL(D2), .BLANK(B2)) u_dut2 (
        .clk(clk), .clr(clr), .en(en), .m_in(m_in),
        .col(col2), .lin(lin2), .frame_sync(fs2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is a position 0..P-1; position 0 is the snapshot slot,
    // then each column occupies B dark slots followed by D lit slots.
    bit          run1 = 1'b0, run2 = 1'b0;
    int          p1 = 0, p2 = 0;
    logic [34:0] pat1 = ONES, pat2 = ONES;

    function automatic logic [12:0] expect_out(input bit run, input int p,
                                               input logic [34:0] pat,
                                               input int b, input int d);
        logic [4:0] c_v;
        logic [6:0] l_v;
        int q, c, w;
        c_v = 5'b0;
        l_v = 7'h7F;
        if (!run) return {1'b0, c_v, l_v};
        if (p == 0) return {1'b1, c_v, l_v};
        q = p - 1;
        c = q / (b + d);
        w = q % (b + d);
        if (w >= b) begin
            c_v[c] = 1'b1;
            for (int r = 0; r < 7; r++) l_v[r] = pat[34 - 5 * r - c];
        end
        return {1'b0, c_v, l_v};
    endfunction

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            run1 <= 1'b0; p1 <= 0; pat1 <= ONES;
            run2 <= 1'b0; p2 <= 0; pat2 <= ONES;
        end else begin
            if (!run1) begin
                if (en) begin run1 <= 1'b1; p1 <= 0; end
            end else begin
                if (p1 == 0) pat1 <= m_in;
                if (p1 == P1 - 1) begin p1 <= 0; run1 <= en; end
                else p1 <= p1 + 1;
            end
            if (!run2) begin
                if (en) begin run2 <= 1'b1; p2 <= 0; end
            end else begin
                if (p2 == 0) pat2 <= m_in;
                if (p2 == P2 - 1) begin p2 <= 0; run2 <= en; end
                else p2 <= p2 + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_dut1", {19'b0, fs1, col1, lin1}, {19'b0, expect_out(run1, p1, pat1, B1, D1)});
        chk("model_dut2", {19'b0, fs2, col2, lin2}, {19'b0, expect_out(run2, p2, pat2, B2, D2)});
    end

    int fs_cnt, lit0_cnt, bad_cnt, first_i, last_i, last_fs, gap_bad, fs2_cnt;
    logic [4:0] prev_nz;
    logic [4:0] seq[$];
    bit found;

    initial begin
        // Reset held with en high: everything dark.
        repeat (3) begin
            @(negedge clk);
            chk("reset_dut1", {19'b0, fs1, col1, lin1}, 32'h7F);
            chk("reset_dut2", {19'b0, fs2, col2, lin2}, 32'h7F);
        end
        @(posedge clk); #1 clr = 1'b1; en = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("idle_dut1", {19'b0, fs1, col1, lin1}, 32'h7F);
        end

        // Single frame, only top-left LED lit.
        @(posedge clk); #1 en = 1'b1; m_in = {1'b0, {34{1'b1}}};
        @(posedge clk); #1 en = 1'b0;
        fs_cnt = 0; lit0_cnt = 0; bad_cnt = 0; first_i = -1; last_i = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fs1) begin fs_cnt++; if (first_i < 0) first_i = i; end
            if (col1 == 5'b00001 && lin1 == 7'b1111110) lit0_cnt++;
            if (col1 != 5'b0 && col1 != 5'b00001 && lin1 != 7'h7F) bad_cnt++;
            if (col1 != 5'b0) last_i = i;
        end
        chk("single_fs_pulses", fs_cnt, 1);
        chk("single_fs_first", first_i, 0);
        chk("single_col0_lit", lit0_cnt, 4);
        chk("single_other_cols_dark", bad_cnt, 0);
        chk("single_frame_len", last_i + 1, 26);

        // Continuous scan, all LEDs lit.
        @(posedge clk); #1 en = 1'b1; m_in = 35'h0;
        @(posedge clk); #1;
        fs_cnt = 0; last_fs = -1; gap_bad = 0; bad_cnt = 0; fs2_cnt = 0;
        prev_nz = 5'b0; seq.delete();
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (fs1) begin
                if (last_fs >= 0 && i - last_fs != 26) gap_bad++;
                last_fs = i;
                fs_cnt++;
            end
            if (col1 != 5'b0 && col1 != prev_nz) begin seq.push_back(col1); prev_nz = col1; end
            if (col1 != 5'b0 && lin1 != 7'h00) bad_cnt++;
            if ((col2 == 5'b0) != fs2) bad_cnt++;
            if (fs2) fs2_cnt++;
        end
        chk("cont_fs_pulses", fs_cnt, 4);
        chk("cont_fs_period", gap_bad, 0);
        chk("cont_lin_and_gapless", bad_cnt, 0);
        chk("cont_fs2_pulses", fs2_cnt, 14);
        chk("cont_seq_len_ok", 32'(seq.size() >= 5), 1);
        if (seq.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("cont_col_seq", {27'b0, seq[k]}, 32'(1) << k);
        end
        @(posedge clk); #1 en = 1'b0;
        repeat (40) @(negedge clk);

        // Snapshot isolation: pattern changes right after capture.
        @(posedge clk); #1 en = 1'b1; m_in = ONES;
        @(posedge clk); #1;
        @(posedge clk); #1 m_in = 35'h0;
        bad_cnt = 0; lit0_cnt = 0;
        for (int i = 1; i < 52; i++) begin
            @(negedge clk);
            if (i < 26 && lin1 != 7'h7F) bad_cnt++;
            if (i >= 26 && col1 != 5'b0 && lin1 == 7'h00) lit0_cnt++;
        end
        chk("iso_frame1_dark", bad_cnt, 0);
        chk("iso_frame2_lit", lit0_cnt, 20);
        @(posedge clk); #1 en = 1'b0;
        repeat (40) @(negedge clk);

        // Reset during column 2.
        @(posedge clk); #1 en = 1'b1; m_in = 35'h0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (col1 == 5'b00100) found = 1'b1;
        end
        chk("midreset_reached_col2", 32'(found), 1);
        #2 clr = 1'b0;
        #1 chk("midreset_async_dut1", {19'b0, fs1, col1, lin1}, 32'h7F);
        chk("midreset_async_dut2", {19'b0, fs2, col2, lin2}, 32'h7F);
        @(posedge clk); #1;
        @(posedge clk); #1 clr = 1'b1;
        @(negedge clk);
        chk("restart_idle", {19'b0, fs1, col1, lin1}, 32'h7F);
        @(negedge clk);
        chk("restart_load", {19'b0, fs1, col1, lin1}, {19'b0, 1'b1, 5'b0, 7'h7F});
        @(negedge clk);
        chk("restart_blank", {19'b0, fs1, col1, lin1}, 32'h7F);
        @(negedge clk);
        chk("restart_col0", {19'b0, fs1, col1, lin1}, {19'b0, 1'b0, 5'b00001, 7'h00});
        @(posedge clk); #1 en = 1'b0;
        repeat (40) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/modulo_varredura_matriz.md
Name: modulo_varredura_matriz

Overview:
Reader and display driver for the 35-bit 5x7 LED-matrix pattern held in the matrix register bank.
- Takes a snapshot of the pattern once per frame.
- Scans it column by column onto a 5-column by 7-row multiplexed LED matrix, with a blanking gap between columns to prevent ghosting.
- Sits between the pattern register bank and the board LED-matrix pins.

Parameters:
DWELL, 4, clock cycles each column is shown (1 to 65535)
BLANK, 1, clock cycles with all outputs off before each column (0 to 255; 0 means no blanking)

Ports:
clk  input  1  single system clock, rising edge
clr  input  1  asynchronous active-low reset
en  input  1  scan enable; sampled only at frame boundaries
m_in  input  35  pattern; bit = 0 means LED lit, bit = 1 means LED off (all-ones is a blank display)
col  output  5  column enable, one-hot, active-high; col[0] is the leftmost column
lin  output  7  row drive, active-low; lin[0] is the top row
frame_sync  output  1  one-cycle pulse marking the snapshot cycle of each frame

Behaviour:
- Reset (clr = 0, asynchronous) sets:
  - col = 5'b00000, lin = 7'h7F, frame_sync = 0
  - snapshot register = all ones
  - state = IDLE, column index = 0, cycle counter = 0
- Reset mid-frame aborts the scan immediately with the same values. The first edge after clr rises evaluates IDLE.
- All outputs are registered, and the outputs are a pure function of the state registers.
- Bit mapping: row r (0..6), column c (0..4) uses snapshot bit index 34 - (5r + c). Bit 34 is top-left; the pattern is row-major, 5 bits per row.
- State IDLE:
  - col = 0, lin = 7F.
  - At a rising edge with en = 1, go to LOAD.
- State LOAD (exactly 1 cycle):
  - frame_sync = 1; col = 0, lin = 7F.
  - At the end of the cycle, capture m_in into the snapshot and set column index = 0.
  - Next state is BLANK, or SHOW if BLANK = 0.
- State BLANK (BLANK cycles): col = 0, lin = 7F, then go to SHOW.
- State SHOW (DWELL cycles):
  - col = one-hot(index).
  - lin[r] = snapshot[34 - 5r - index] for r = 0..6, passed straight through.
- End of SHOW, index < 4: index + 1, go to BLANK (or SHOW if BLANK = 0).
- End of SHOW, index = 4 (wrap):
  - index = 0.
  - en = 1: go to LOAD.
  - en = 0: go to IDLE.
- Frame period = 1 + 5 × (BLANK + DWELL) cycles. The LOAD slot is counted each frame.
- en falling mid-frame has no effect until the frame ends; the current frame always completes.
- m_in changes mid-frame are ignored until the next LOAD. A change in the same cycle as the LOAD edge is captured.
- Exactly one col bit is high in SHOW; none is high in IDLE, LOAD or BLANK.
- Cycle counter: 16 bits, counts 0..N-1 for the current state's duration, then clears on every state change.

Decomposition:
- Shared package holds:
  - NUM_ROWS = 7, NUM_COLS = 5, PATTERN_W = 35
  - LIN_OFF = 7'h7F
  - state enum {IDLE, LOAD, BLANK, SHOW}
  - function bit_index(r, c) = 34 - 5r - c
- One sub-module, modulo_sel_coluna: combinational extraction of a 7-bit column from the 35-bit snapshot and a 3-bit index. Reusable by any future matrix reader.
- Top level: state machine, cycle counter, column index, snapshot register and output registers.

Test Plan:
- Reset/idle: clr low for 3 cycles with en = 1 -> col = 0, lin = 7F, frame_sync = 0 throughout. Release clr with en = 0 for 20 cycles -> outputs unchanged.
- Single frame, DWELL = 4, BLANK = 1, m_in = all ones except bit 34 = 0, en = 1 for one edge then 0:
  - frame_sync high for exactly 1 cycle.
  - Column 0: col = 5'b00001, lin = 7'b1111110 for 4 cycles.
  - Columns 1 to 4: lin = 7F.
  - Each SHOW is preceded by 1 blank cycle.
  - 26 cycles total, then IDLE.
- Continuous scan, en held at 1, m_in = 35'h0 -> frame_sync pulses every 26 cycles. col sequence 01, 02, 04, 08, 10 with lin = 00 in each SHOW window.
- Snapshot isolation: m_in = all ones at LOAD, then 35'h0 two cycles later -> whole frame shows lin = 7F. The next frame shows lin = 00.
- BLANK = 0, DWELL = 1 -> frame period 6. col changes every cycle with no zero gap between columns. col = 0 only in the LOAD cycle.
- Reset mid-frame: assert clr during column 2 SHOW -> col = 0 and lin = 7F immediately, without waiting for a clock. After release with en = 1, the next frame starts with LOAD and column 0.
